// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer driving an external 1-bit slice, LSB first; WIDTH cycles per op (2*WIDTH for SLT),
// done one cycle after the last bit. start is only accepted in IDLE, so requests while busy are dropped.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_a_invert,
  output logic             alu_b_invert,
  output logic             alu_carry_in,
  output logic             alu_less,
  output logic [1:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  localparam logic [1:0] SL_AND  = 2'd0;
  localparam logic [1:0] SL_OR   = 2'd1;
  localparam logic [1:0] SL_SUM  = 2'd2;
  localparam logic [1:0] SL_LESS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLT2,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             set_q, set_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic is_sub, is_slt, is_addsub;

  assign is_slt    = (op_q == OP_SLT);
  assign is_sub    = (op_q == OP_SUB) || is_slt;
  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);

  assign busy      = busy_q;
  assign done      = done_q;
  assign y         = y_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  // Slice drive is decoded from registered state only, so it is quiet in IDLE/DONE and under reset.
  always_comb begin
    alu_a        = 1'b0;
    alu_b        = 1'b0;
    alu_a_invert = 1'b0;
    alu_b_invert = 1'b0;
    alu_carry_in = 1'b0;
    alu_less     = 1'b0;
    alu_op       = SL_AND;
    if (state_q == S_RUN || state_q == S_SLT2) begin
      alu_a        = a_q[cnt_q];
      alu_b        = b_q[cnt_q];
      alu_carry_in = (cnt_q == '0) ? is_sub : carry_q;
    end
    if (state_q == S_RUN) begin
      case (op_q)
        OP_OR:  alu_op = SL_OR;
        OP_NOR: begin
          alu_a_invert = 1'b1;
          alu_b_invert = 1'b1;
          alu_op       = SL_AND;
        end
        OP_ADD: alu_op = SL_SUM;
        OP_SUB, OP_SLT: begin
          alu_b_invert = 1'b1;
          alu_op       = SL_SUM;
        end
        default: alu_op = SL_AND;
      endcase
    end else if (state_q == S_SLT2) begin
      alu_b_invert = 1'b1;
      alu_op       = SL_LESS;
      alu_less     = (cnt_q == '0) ? set_q : 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sreg_d      = sreg_q;
    set_d       = set_q;
    cout_d      = cout_q;
    y_d         = y_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_sel;
          cnt_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN, S_SLT2: begin
        sreg_d  = {alu_result, sreg_q[WIDTH-1:1]};
        carry_d = alu_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (state_q == S_RUN && is_slt) begin
            // Sign of a-b corrected by overflow gives the signed less-than bit.
            set_d   = alu_result ^ (alu_carry_in ^ alu_carry);
            cout_d  = alu_carry;
            state_d = S_SLT2;
          end else begin
            y_d     = sreg_d;
            zero_d  = (sreg_d == '0);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
            if (state_q == S_SLT2) begin
              carry_out_d = cout_q;
              overflow_d  = 1'b0;
            end else begin
              carry_out_d = is_addsub ? alu_carry : 1'b0;
              overflow_d  = is_addsub ? (alu_carry_in ^ alu_carry) : 1'b0;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      sreg_q      <= '0;
      set_q       <= 1'b0;
      cout_q      <= 1'b0;
      y_q         <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sreg_q      <= sreg_d;
      set_q       <= set_d;
      cout_q      <= cout_d;
      y_q         <= y_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl with a behavioural 1-bit ALU slice and an arithmetic reference model.
module tb_serial_alu_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op_sel = 3'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] y;
  logic         alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_less;
  logic [1:0]   alu_op;
  logic         alu_result, alu_carry;
  logic         sl_a, sl_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_sel(op_sel),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .y(y),
    .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_a_invert(alu_a_invert),
    .alu_b_invert(alu_b_invert), .alu_carry_in(alu_carry_in),
    .alu_less(alu_less), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // Behavioural 1-bit slice
  assign sl_a = alu_a ^ alu_a_invert;
  assign sl_b = alu_b ^ alu_b_invert;
  assign alu_carry = (sl_a & sl_b) | (sl_a & alu_carry_in) | (sl_b & alu_carry_in);
  assign alu_result = (alu_op == 2'd0) ? (sl_a & sl_b) :
                      (alu_op == 2'd1) ? (sl_a | sl_b) :
                      (alu_op == 2'd2) ? (sl_a ^ sl_b ^ alu_carry_in) : alu_less;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {carry_out, overflow, zero, y}
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd4: begin
        r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
        c = (a >= b);
      end
      3'd5: r = ~(a | b);
      default: r = a & b;
    endcase
    return {c, v, (r == 8'd0), r};
  endfunction

  function automatic logic [7:0] alu_bus();
    return {alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_less, alu_op};
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [10:0] m;
    int k;
    m = model(op, a, b);
    @(negedge clk);
    op_sel = op; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_sel = 3'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
    check({tag, ":busy"}, busy, 1);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, ":latency"}, k, (op == 3'd4) ? 2 * W : W);
    check({tag, ":y"}, y, m[7:0]);
    check({tag, ":zero"}, zero, m[8]);
    check({tag, ":ovf"}, overflow, m[9]);
    check({tag, ":cout"}, carry_out, m[10]);
    check({tag, ":busy_done"}, busy, 0);
    check({tag, ":alu_quiet"}, alu_bus(), 0);
    @(negedge clk);
    check({tag, ":done_pulse"}, done, 0);
  endtask

  initial begin
    int k;
    int dcount;
    #2;
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:y", y, 0);
    check("rst:flags", {carry_out, overflow, zero}, 0);
    check("rst:alu", alu_bus(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("add_ovf", 3'd2, 8'h7F, 8'h01);
    run_op("sub_zero", 3'd3, 8'h05, 8'h05);
    run_op("slt_neg", 3'd4, 8'h80, 8'h01);
    run_op("slt_ovf", 3'd4, 8'h7F, 8'h80);
    run_op("nor", 3'd5, 8'hF0, 8'h0C);
    run_op("and", 3'd0, 8'hF0, 8'h3C);
    run_op("or", 3'd1, 8'h50, 8'h0A);
    run_op("op7_and", 3'd7, 8'hAA, 8'h0F);
    run_op("add_cout", 3'd2, 8'hFF, 8'h01);

    for (int i = 0; i < 25; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end

    // Abort an ADD at bit 3 with reset.
    run_op("pre_abort_or", 3'd1, 8'h5A, 8'h21);
    @(negedge clk);
    op_sel = 3'd2; a_in = 8'h10; b_in = 8'h20; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort:busy", busy, 0);
    check("abort:y", y, 0);
    check("abort:done", done, 0);
    check("abort:flags", {carry_out, overflow, zero}, 0);
    check("abort:alu", alu_bus(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("abort:no_done", dcount, 0);
    run_op("post_abort_add", 3'd2, 8'h02, 8'h03);

    // start held high with new operands while busy: first op unaffected, next begins after DONE.
    @(negedge clk);
    op_sel = 3'd2; a_in = 8'h11; b_in = 8'h22; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_sel = 3'd3; a_in = 8'h50; b_in = 8'h10;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("hold:lat1", k, W);
    check("hold:y1", y, 8'h33);
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 100);
    start = 1'b0;
    check("hold:gap", k, W + 2);
    check("hold:y2", y, 8'h40);
    check("hold:cout2", carry_out, 1);
    repeat (3) @(negedge clk);
    check("hold:idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
